aggregate: RTL and testbench
============================

AGGREGATE -- requirements
Module: aggregate

Interface
REQ-001 Parameter OUT_WIDTH, default 32, output word width in bits; SHALL be even and ≥2.
REQ-002 clk  input  1  single system clock; all logic SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (asserted when 0), sampled on rising clk.
REQ-004 axiiv  input  1  input dibit valid; a packet is a maximal run of consecutive cycles with axiiv=1.
REQ-005 axiid  input  2  input dibit, meaningful only when axiiv=1.
REQ-006 axiov  output  1  one-cycle pulse; axiod carries a completed word.
REQ-007 axiod  output  OUT_WIDTH  aggregated word (first OUT_WIDTH/2 dibits of the packet).

Function
REQ-008 The module SHALL capture the first N=OUT_WIDTH/2 dibits of each packet, MSB-first: the first dibit lands in axiod[OUT_WIDTH-1:OUT_WIDTH-2], the Nth in axiod[1:0].
REQ-009 States SHALL be IDLE, COLLECT and DRAIN.
REQ-010 IDLE: on axiiv=1, shift in axiid, set count=1, go to COLLECT; otherwise stay.
REQ-011 COLLECT: on axiiv=1, shift in axiid and increment count; when count reaches N, go to DRAIN.
REQ-012 COLLECT: on axiiv=0 with count<N, discard the partial word, emit nothing, go to IDLE.
REQ-013 DRAIN: dibits beyond the Nth SHALL be ignored and the captured word SHALL NOT change while axiiv=1.
REQ-014 DRAIN: at the first rising edge sampling axiiv=0, axiov SHALL be registered to 1 for exactly one cycle with axiod=captured word; next state IDLE.
REQ-015 Latency: axiov is high during the cycle immediately following the first axiiv=0 cycle after a packet of ≥N dibits.
REQ-016 A packet of exactly N dibits SHALL behave as in REQ-014 (COLLECT→DRAIN on the Nth dibit, emit on the following axiiv=0).
REQ-017 axiod SHALL hold the last emitted word between pulses; the assembly register SHALL be separate from axiod.
REQ-018 A new packet SHALL be accepted on the cycle that axiov pulses for the previous one (one idle cycle between packets suffices); the emitted word SHALL be unaffected.
REQ-019 The dibit counter SHALL be ceil(log2(N+1)) bits and SHALL saturate at N (no wrap on long packets).
REQ-020 There is no backpressure; axiov is never stalled.

Reset
REQ-021 While rst=0 at a rising edge: state←IDLE, count←0, assembly register←0, axiov←0, axiod←0.
REQ-022 Reset mid-packet SHALL abandon the partial word with no output; after release, the first sampled axiiv=1 starts a new packet.

Structure
REQ-023 Package aggregate_pkg SHALL hold the state enum (IDLE, COLLECT, DRAIN) and the default constants (OUT_WIDTH=32, DIBITS_PER_WORD=16).
REQ-024 One sub-module, dibit_shift_reg (shift-left-by-2 with load-enable and clear), SHALL hold the assembly register; the FSM, counter and output registers live in aggregate.

Verification
REQ-025 Reset: rst=0 for one edge → axiov=0, axiod=0x00000000.
REQ-026 Packet of 65 dibits: first 32 are i%4 (0,1,2,3 repeating), then 33 zeros, then axiiv=0 → one axiov pulse with axiod=0x1B1B1B1B, then axiov=0 and axiod holds.
REQ-027 Exactly 16 dibits of 3 then axiiv=0 → axiov=1 for one cycle, one cycle after axiiv falls, axiod=0xFFFFFFFF.
REQ-028 15 dibits of 1 then axiiv=0 → axiov stays 0; axiod keeps its previous value.
REQ-029 Two 16-dibit packets (all 1s, then all 2s) separated by one idle cycle → two pulses with 0x55555555 then 0xAAAAAAAA.
REQ-030 rst=0 after 8 dibits of a packet, released with axiiv still high for 16 more dibits of 2, then axiiv=0 → one pulse, axiod=0xAAAAAAAA.

Source files
------------

// File: rtl/aggregate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aggregate_pkg                                             |
// | Purpose  : Shared types and default constants for the dibit          |
// |            aggregator (state encoding, word/dibit sizing).           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package aggregate_pkg;

  // Aggregator control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int DEFAULT_OUT_WIDTH = 32;
  localparam int DIBITS_PER_WORD   = DEFAULT_OUT_WIDTH / 2;

  // Bits needed for a counter that must reach n without wrapping.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage : aggregate_pkg
`default_nettype wire

// File: rtl/dibit_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dibit_shift_reg                                           |
// | Purpose  : Assembly register. Shifts left by two bits, inserting     |
// |            a new dibit at the LSBs when enabled. Clear empties it;   |
// |            clear together with enable loads a single fresh dibit.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dibit_shift_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [1:0]   din,
  output logic [W-1:0] q
);

  logic [W-1:0] base;
  logic [W-1:0] q_nxt;

  // Starting point for the shift: empty when starting over, else current.
  assign base = clr ? '0 : q;

  generate
    if (W == 2) begin : g_single_dibit
      assign q_nxt = en ? din : base;
    end else begin : g_multi_dibit
      assign q_nxt = en ? {base[W-3:0], din} : base;
    end
  endgenerate

  // Assembly register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule : dibit_shift_reg
`default_nettype wire

// File: rtl/aggregate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aggregate                                                 |
// | Purpose  : Collects the first OUT_WIDTH/2 dibits of each packet      |
// |            MSB-first and emits the word as a one-cycle pulse after   |
// |            the packet ends. Short packets are dropped silently.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module aggregate
  import aggregate_pkg::*;
#(
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axiiv,
  input  logic [1:0]           axiid,
  output logic                 axiov,
  output logic [OUT_WIDTH-1:0] axiod
);

  localparam int N  = OUT_WIDTH / 2;
  localparam int CW = count_width(N);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam state_t        FIRST_NXT = (N == 1) ? DRAIN : COLLECT;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            sr_en;
  logic            sr_clr;
  logic            emit;
  logic [OUT_WIDTH-1:0] sr_q;

  dibit_shift_reg #(
    .W (OUT_WIDTH)
  ) u_shift (
    .clk (clk),
    .rst (rst),
    .clr (sr_clr),
    .en  (sr_en),
    .din (axiid),
    .q   (sr_q)
  );

  // State, counter and output registers; axiod only changes on emit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      axiov <= 1'b0;
      axiod <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      axiov <= emit;
      if (emit) begin
        axiod <= sr_q;
      end
    end
  end

  // Next-state, counter and shift-register control.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sr_en     = 1'b0;
    sr_clr    = 1'b0;
    emit      = 1'b0;
    case (state)
      IDLE: begin
        if (axiiv) begin
          // Start a fresh word with this dibit, discarding stale content.
          sr_en     = 1'b1;
          sr_clr    = 1'b1;
          count_nxt = ONE_C;
          state_nxt = FIRST_NXT;
        end
      end
      COLLECT: begin
        if (axiiv) begin
          sr_en = 1'b1;
          if (count < N_C) begin
            count_nxt = count + ONE_C;
          end
          if (count == N_C - ONE_C) begin
            state_nxt = DRAIN;
          end
        end else begin
          // Packet ended before a full word: drop it.
          sr_clr    = 1'b1;
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        // Extra dibits are ignored; count stays saturated at N.
        if (!axiiv) begin
          emit      = 1'b1;
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule : aggregate
`default_nettype wire

// File: tb/tb_aggregate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_aggregate                                              |
// | Purpose  : Self-checking bench for aggregate: directed packets plus  |
// |            random packets compared against a packet-level model.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_aggregate;

  localparam int OUT_WIDTH = 32;
  localparam int N = OUT_WIDTH / 2;

  logic                 clk;
  logic                 rst;
  logic                 axiiv;
  logic [1:0]           axiid;
  logic                 axiov;
  logic [OUT_WIDTH-1:0] axiod;

  int n_checks;
  int n_errors;

  // Model state: dibits of the packet in progress and expected outputs.
  logic [1:0]           pkt[$];
  int                   pkt_len;
  logic                 exp_ov;
  logic [OUT_WIDTH-1:0] exp_od;

  aggregate #(
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiov (axiov),
    .axiod (axiod)
  );

  initial clk = 1'b0;
  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Word made of the first N dibits of the current packet, first dibit at MSBs.
  function automatic logic [OUT_WIDTH-1:0] pack_word();
    logic [OUT_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      w = w * 4 + OUT_WIDTH'(pkt[i]);
    end
    return w;
  endfunction

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input logic r, input logic v, input logic [1:0] d);
    @(negedge clk);
    rst   = r;
    axiiv = v;
    axiid = d;
    @(posedge clk);
    #1;
    if (!r) begin
      pkt.delete();
      pkt_len = 0;
      exp_ov  = 1'b0;
      exp_od  = '0;
    end else begin
      exp_ov = 1'b0;
      if (v) begin
        if (pkt.size() < N) pkt.push_back(d);
        pkt_len++;
      end else begin
        if (pkt_len >= N) begin
          exp_ov = 1'b1;
          exp_od = pack_word();
        end
        pkt.delete();
        pkt_len = 0;
      end
    end
    check("axiov", 32'(axiov), 32'(exp_ov));
    check("axiod", axiod, exp_od);
  endtask

  task automatic send(input int len, input logic [1:0] d);
    for (int i = 0; i < len; i++) cycle(1'b1, 1'b1, d);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pkt_len  = 0;
    exp_ov   = 1'b0;
    exp_od   = '0;
    rst      = 1'b0;
    axiiv    = 1'b0;
    axiid    = 2'd0;

    // Reset state.
    cycle(1'b0, 1'b0, 2'd0);
    check("rst_ov", 32'(axiov), 32'd0);
    check("rst_od", axiod, 32'h0000_0000);
    cycle(1'b1, 1'b0, 2'd0);

    // 65-dibit packet: 0,1,2,3 pattern then zeros; counter must saturate.
    for (int i = 0; i < 65; i++) cycle(1'b1, 1'b1, (i < 32) ? 2'(i % 4) : 2'd0);
    cycle(1'b1, 1'b0, 2'd0);
    check("long_ov", 32'(axiov), 32'd1);
    check("long_od", axiod, 32'h1B1B_1B1B);
    cycle(1'b1, 1'b0, 2'd0);
    check("long_ov_drop", 32'(axiov), 32'd0);
    check("long_od_hold", axiod, 32'h1B1B_1B1B);

    // Exactly N dibits of 3.
    send(N, 2'd3);
    check("exact_no_early", 32'(axiov), 32'd0);
    cycle(1'b1, 1'b0, 2'd0);
    check("exact_ov", 32'(axiov), 32'd1);
    check("exact_od", axiod, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 2'd0);
    check("exact_ov_drop", 32'(axiov), 32'd0);

    // N-1 dibits: dropped, previous word held.
    send(N - 1, 2'd1);
    cycle(1'b1, 1'b0, 2'd0);
    check("short_ov", 32'(axiov), 32'd0);
    check("short_od", axiod, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 2'd0);

    // Back-to-back packets with a single idle cycle.
    send(N, 2'd1);
    cycle(1'b1, 1'b0, 2'd0);
    check("b2b_ov1", 32'(axiov), 32'd1);
    check("b2b_od1", axiod, 32'h5555_5555);
    send(N, 2'd2);
    check("b2b_hold", axiod, 32'h5555_5555);
    cycle(1'b1, 1'b0, 2'd0);
    check("b2b_ov2", 32'(axiov), 32'd1);
    check("b2b_od2", axiod, 32'hAAAA_AAAA);
    cycle(1'b1, 1'b0, 2'd0);

    // Reset mid-packet, released while axiiv stays high.
    send(8, 2'd1);
    cycle(1'b0, 1'b1, 2'd3);
    check("midrst_od", axiod, 32'h0000_0000);
    send(N, 2'd2);
    cycle(1'b1, 1'b0, 2'd0);
    check("midrst_ov", 32'(axiov), 32'd1);
    check("midrst_od2", axiod, 32'hAAAA_AAAA);
    cycle(1'b1, 1'b0, 2'd0);

    // Random packets around the word-length boundary, rare resets.
    for (int p = 0; p < 300; p++) begin
      int len;
      int gap;
      len = (p % 3 == 0) ? $urandom_range(N - 1, N + 1) : $urandom_range(0, 40);
      gap = $urandom_range(1, 3);
      for (int j = 0; j < len; j++)
        cycle(($urandom_range(0, 199) != 0), 1'b1, 2'($urandom_range(0, 3)));
      for (int j = 0; j < gap; j++) cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_aggregate
`default_nettype wire
